// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_MIS,
        SEL_REDIR,
        SEL_RAS,
        SEL_SEQ,
        SEL_HOLD
    } pc_sel_e;

    // True when the low `align` bits of addr are all zero.
    function automatic logic is_aligned(input logic [63:0] addr, input int align);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < align && addr[i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push-when-full overwrites the oldest entry,
// push+pop together replace the top entry, clear empties the stack.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;

    assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);

    assign top_o   = mem_q[ptr_q];
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i && pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end else if (push_i) begin
            mem_q[ptr_inc] <= push_data_i;
            ptr_q          <= ptr_inc;
            if (cnt_q != CW'(DEPTH)) cnt_q <= cnt_q + CW'(1);
        end else if (pop_i) begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT FSM, trap/redirect/sequential priority mux.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              ALIGN     = 2,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] epc,
    output logic            misalign,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    input  logic            ras_push,
    input  logic            ras_pop
);

    pc_state_e       state_q, state_d;
    pc_sel_e         sel;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;
    logic            target_ok;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    assign target_ok = is_aligned(64'(redir_target), ALIGN);

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (sel == SEL_TRAP),
        .push_i      (en && state_q == RUN && ras_push),
        .pop_i       (sel == SEL_RAS),
        .push_data_i (pc_q + XLEN'(INC)),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_in;
    assign unused_ras_in = ras_push ^ ras_pop;
    assign ras_top       = '0;
    assign ras_empty     = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     if (halt_req && !trap_valid && !redir_valid) state_d = HALT;
                HALT:    if (resume) state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    // Traps and redirects win over the handshake, so pc_ready is only consulted last.
    always_comb begin
        sel = SEL_HOLD;
        if (en) begin
            if (state_q == RUN) begin
                if (trap_valid)                     sel = SEL_TRAP;
                else if (redir_valid && !target_ok) sel = SEL_MIS;
                else if (redir_valid)               sel = SEL_REDIR;
                else if (ras_pop && !ras_empty)     sel = SEL_RAS;
                else if (pc_ready)                  sel = SEL_SEQ;
            end else if (state_q == HALT) begin
                if (trap_valid) sel = SEL_TRAP;
            end
        end
    end

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        mis_d = en ? (sel == SEL_MIS) : mis_q;
        case (sel)
            SEL_TRAP: begin
                pc_d  = trap_vec;
                epc_d = pc_q;
            end
            SEL_MIS: begin
                pc_d  = trap_vec;
                epc_d = redir_target;
            end
            SEL_REDIR: pc_d = redir_target;
            SEL_RAS:   pc_d = ras_top;
            SEL_SEQ:   pc_d = pc_q + XLEN'(INC);
            default:   pc_d = pc_q;
        endcase
    end

    always_comb begin
        pc_valid = (state_q == RUN);
        halted   = (state_q == HALT);
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_pc_gen;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en, pc_ready, redir_valid, trap_valid, halt_req, resume, ras_push, ras_pop;
    logic [31:0] redir_target, trap_vec;
    logic [31:0] pc, epc;
    logic        pc_valid, misalign, halted;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (RV),
        .INC       (4),
        .ALIGN     (2),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .trap_valid   (trap_valid),
        .trap_vec     (trap_vec),
        .epc          (epc),
        .misalign     (misalign),
        .halt_req     (halt_req),
        .resume       (resume),
        .halted       (halted),
        .ras_push     (ras_push),
        .ras_pop      (ras_pop)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_pc, m_epc;
    bit          m_mis, m_run, m_halt;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RV;
        m_epc  = '0;
        m_mis  = 0;
        m_run  = 0;
        m_halt = 0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [31:0] cur;
        cur = m_pc;
        if (!en) return;
        if (!m_run && !m_halt) begin
            m_run = 1;
            return;
        end
        if (m_halt) begin
            m_mis = 0;
            if (trap_valid) begin
                m_epc = cur;
                m_pc  = trap_vec;
                m_ras.delete();
            end
            if (resume) begin
                m_halt = 0;
                m_run  = 1;
            end
            return;
        end
        m_mis = 0;
        if (trap_valid) begin
            m_epc = cur;
            m_pc  = trap_vec;
            m_ras.delete();
        end else if (redir_valid && (redir_target % 4) != 0) begin
            m_epc = redir_target;
            m_pc  = trap_vec;
            m_mis = 1;
        end else if (redir_valid) begin
            m_pc = redir_target;
`ifdef PC_RAS_EN
        end else if (ras_pop && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
`endif
        end else if (pc_ready) begin
            m_pc = cur + 32'd4;
        end
`ifdef PC_RAS_EN
        if (ras_push && !trap_valid) begin
            if (m_ras.size() == DEPTH) m_ras.delete(0);
            m_ras.push_back(cur + 32'd4);
        end
`endif
        if (halt_req && !trap_valid && !redir_valid) begin
            m_run  = 0;
            m_halt = 1;
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("epc", epc, m_epc);
        chk("pc_valid", 32'(pc_valid), 32'(m_run));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("misalign", 32'(misalign), 32'(m_mis));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        en           = 1'b1;
        pc_ready     = 1'b0;
        redir_valid  = 1'b0;
        redir_target = '0;
        trap_valid   = 1'b0;
        halt_req     = 1'b0;
        resume       = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, RV);
        chk("async_rst_valid", 32'(pc_valid), 32'd0);
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        idle();
        trap_vec = 32'h800;
        rst      = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        chk("reset_pc", pc, RV);
        chk("reset_valid", 32'(pc_valid), 32'd0);
        rst = 1'b0;

        tick();
        chk("boot_exit_valid", 32'(pc_valid), 32'd1);
        chk("boot_exit_pc", pc, 32'h100);

        pc_ready = 1'b1;
        tick(); chk("seq1", pc, 32'h104);
        tick(); chk("seq2", pc, 32'h108);
        tick(); chk("seq3", pc, 32'h10C);
        pc_ready = 1'b0;
        tick(); chk("stall", pc, 32'h10C);

        redir_valid = 1'b1; redir_target = 32'h200;
        tick(); chk("redir", pc, 32'h200);
        redir_target = 32'h300; trap_valid = 1'b1;
        tick(); chk("trap_pc", pc, 32'h800); chk("trap_epc", epc, 32'h200);
        trap_valid = 1'b0; redir_target = 32'h102;
        tick(); chk("mis_pc", pc, 32'h800); chk("mis_epc", epc, 32'h102);
        chk("mis_pulse", 32'(misalign), 32'd1);
        redir_valid = 1'b0;
        tick(); chk("mis_clear", 32'(misalign), 32'd0);

        halt_req = 1'b1;
        tick(); chk("halt", 32'(halted), 32'd1); chk("halt_valid", 32'(pc_valid), 32'd0);
        halt_req = 1'b0; pc_ready = 1'b1; redir_valid = 1'b1; redir_target = 32'h400;
        tick(); tick(); chk("halt_hold", pc, 32'h800);
        redir_valid = 1'b0; resume = 1'b1;
        tick(); chk("resume", 32'(halted), 32'd0);
        resume = 1'b0;
        tick(); chk("resume_adv", pc, 32'h804);

        en = 1'b0; trap_valid = 1'b1; trap_vec = 32'h900;
        tick(); tick(); chk("en_hold", pc, 32'h804);
        idle();

        redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0; pc_ready = 1'b1;
        tick(); chk("wrap", pc, 32'h0);
        idle();

`ifdef PC_RAS_EN
        redir_valid = 1'b1; redir_target = 32'h10;
        tick();
        redir_target = 32'h20; ras_push = 1'b1;
        tick();
        redir_target = 32'h40;
        tick();
        idle(); ras_pop = 1'b1;
        tick(); chk("ras_pop1", pc, 32'h24);
        tick(); chk("ras_pop2", pc, 32'h14);
        pc_ready = 1'b1;
        tick(); chk("ras_empty_seq", pc, 32'h18);
        idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            pc_ready    = ($urandom_range(0, 9) < 7);
            redir_valid = ($urandom_range(0, 9) == 0);
            trap_valid  = ($urandom_range(0, 19) == 0);
            halt_req    = ($urandom_range(0, 19) == 0);
            resume      = ($urandom_range(0, 4) == 0);
            ras_push    = ($urandom_range(0, 6) == 0);
            ras_pop     = ($urandom_range(0, 6) == 0);
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v[1:0] = 2'($urandom_range(1, 3));
            else                           v[1:0] = 2'b00;
            redir_target = v;
            v = $urandom;
            v[1:0] = 2'b00;
            trap_vec = v;
            tick();
            if (i % 500 == 250) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
